// File: rtl/shreg_arbiter.sv
// shreg_arbiter: two-requester round-robin arbiter feeding a WIDTH-bit
// MSB-first serialiser. Each grant shifts out one word, then pulses the
// requester's ack.
// Optional build macro SHREG_ARBITER_PARITY_EN appends an even-parity bit
// after the data bits and delays the ack by one cycle.
module shreg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             grant_id,
    output logic             sdo,
    output logic             sdo_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             gid_nxt, sdo_nxt, valid_nxt;
    logic             ack0_nxt, ack1_nxt, busy_nxt;
    logic             win;
    logic [WIDTH-1:0] word_sel;
`ifdef SHREG_ARBITER_PARITY_EN
    logic             par, par_nxt;
`endif

    // Round-robin pick: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        win      = (req0 && req1) ? ~last : req1;
        word_sel = win ? data1 : data0;
    end

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gid_nxt   = grant_id;
        busy_nxt  = busy;
        sdo_nxt   = 1'b0;
        valid_nxt = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
`ifdef SHREG_ARBITER_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (req0 || req1) begin
                    state_nxt = SHIFT;
                    gid_nxt   = win;
                    shreg_nxt = word_sel;
                    cnt_nxt   = '0;
                    sdo_nxt   = word_sel[WIDTH-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
`ifdef SHREG_ARBITER_PARITY_EN
                    par_nxt   = ^word_sel;
`endif
                end
            end
            SHIFT: begin
                busy_nxt  = 1'b1;
                shreg_nxt = shreg << 1;
                cnt_nxt   = cnt + 1'b1;
`ifdef SHREG_ARBITER_PARITY_EN
                if (cnt == CW'(WIDTH)) begin
                    state_nxt = DONE;
                    ack0_nxt  = ~grant_id;
                    ack1_nxt  = grant_id;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    sdo_nxt   = par;
                    valid_nxt = 1'b1;
                end else begin
                    sdo_nxt   = shreg[WIDTH-2];
                    valid_nxt = 1'b1;
                end
`else
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    ack0_nxt  = ~grant_id;
                    ack1_nxt  = grant_id;
                end else begin
                    // sdo is registered, so load the bit that becomes MSB after this shift
                    sdo_nxt   = shreg[WIDTH-2];
                    valid_nxt = 1'b1;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                last_nxt  = grant_id;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath and registered outputs.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            last      <= 1'b1;
            grant_id  <= 1'b0;
            busy      <= 1'b0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
`ifdef SHREG_ARBITER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            grant_id  <= gid_nxt;
            busy      <= busy_nxt;
            sdo       <= sdo_nxt;
            sdo_valid <= valid_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
`ifdef SHREG_ARBITER_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

endmodule
